wb_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter.
- Shares the single master port of the shared-bus intercon between two requesters, e.g. the GPMC bridge and an on-FPGA sequencer.
- Uses round-robin fairness and holds the grant for the whole bus cycle (cycle high).
- A watchdog terminates stalled cycles with an error so a missing slave cannot hang the bus.

---
 rtl/wb_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Two-master to one-slave Wishbone arbiter: round-robin, grant held for the
// whole bus cycle, watchdog kills stalled cycles with an error to the owner.
module wb_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] m0_address,
  input  logic [DATA_WIDTH-1:0] m0_writedata,
  output logic [DATA_WIDTH-1:0] m0_readdata,
  input  logic                  m0_write,
  input  logic                  m0_cycle,
  input  logic                  m0_strobe,
  output logic                  m0_ack,
  output logic                  m0_err,
  input  logic [ADDR_WIDTH-1:0] m1_address,
  input  logic [DATA_WIDTH-1:0] m1_writedata,
  output logic [DATA_WIDTH-1:0] m1_readdata,
  input  logic                  m1_write,
  input  logic                  m1_cycle,
  input  logic                  m1_strobe,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [ADDR_WIDTH-1:0] wbs_address,
  output logic [DATA_WIDTH-1:0] wbs_writedata,
  input  logic [DATA_WIDTH-1:0] wbs_readdata,
  output logic                  wbs_write,
  output logic                  wbs_cycle,
  output logic                  wbs_strobe,
  input  logic                  wbs_ack,
  output logic [1:0]            grant,
  output logic [7:0]            err_count
);

  typedef enum logic [1:0] {IDLE, BUSY, TERM} state_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_owner, last_owner_nxt;
  logic [7:0] wd_cnt, wd_nxt;
  logic [7:0] err_nxt;
  logic       own_cyc, own_stb;

  assign own_cyc = owner ? m1_cycle  : m0_cycle;
  assign own_stb = owner ? m1_strobe : m0_strobe;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      wd_cnt     <= wd_nxt;
      err_count  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    wd_nxt         = wd_cnt;
    err_nxt        = err_count;
    case (state)
      IDLE: begin
        wd_nxt = '0;
        if (m0_cycle && m1_cycle) begin
          owner_nxt = !last_owner;
          state_nxt = BUSY;
        end else if (m0_cycle) begin
          owner_nxt = 1'b0;
          state_nxt = BUSY;
        end else if (m1_cycle) begin
          owner_nxt = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          wd_nxt         = '0;
        end else if (own_stb && !wbs_ack) begin
          // ack in the final watchdog clk falls to the else branch and wins
          if (wd_cnt == WD_LAST) begin
            state_nxt = TERM;
            wd_nxt    = '0;
          end else begin
            wd_nxt = wd_cnt + 8'd1;
          end
        end else begin
          wd_nxt = '0;
        end
      end
      TERM: begin
        state_nxt      = IDLE;
        last_owner_nxt = owner;
        wd_nxt         = '0;
        if (err_count != 8'hFF) err_nxt = err_count + 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wbs_address   = '0;
    wbs_writedata = '0;
    wbs_write     = 1'b0;
    wbs_cycle     = 1'b0;
    wbs_strobe    = 1'b0;
    grant         = 2'b00;
    m0_ack        = 1'b0;
    m1_ack        = 1'b0;
    m0_err        = 1'b0;
    m1_err        = 1'b0;
    m0_readdata   = '0;
    m1_readdata   = '0;
    case (state)
      BUSY: begin
        wbs_address   = owner ? m1_address   : m0_address;
        wbs_writedata = owner ? m1_writedata : m0_writedata;
        wbs_write     = owner ? m1_write     : m0_write;
        wbs_cycle     = own_cyc;
        wbs_strobe    = own_stb;
        grant         = owner ? 2'b10 : 2'b01;
        m0_ack        = !owner && wbs_ack;
        m1_ack        = owner && wbs_ack;
        m0_readdata   = wbs_readdata;
        m1_readdata   = wbs_readdata;
      end
      TERM: begin
        grant  = owner ? 2'b10 : 2'b01;
        m0_err = !owner;
        m1_err = owner;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (TIMEOUT=4): arbitration order, turnaround,
// watchdog termination, ack/timeout tie, err_count saturation, mid-cycle reset.
module tb_wb_arbiter;

  logic        clk, reset;
  logic [15:0] m0_address, m0_writedata, m0_readdata;
  logic        m0_write, m0_cycle, m0_strobe, m0_ack, m0_err;
  logic [15:0] m1_address, m1_writedata, m1_readdata;
  logic        m1_write, m1_cycle, m1_strobe, m1_ack, m1_err;
  logic [15:0] wbs_address, wbs_writedata, wbs_readdata;
  logic        wbs_write, wbs_cycle, wbs_strobe, wbs_ack;
  logic [1:0]  grant;
  logic [7:0]  err_count;

  int total = 0;
  int bad   = 0;

  wb_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
    .m0_write(m0_write), .m0_cycle(m0_cycle), .m0_strobe(m0_strobe),
    .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_address(m1_address), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
    .m1_write(m1_write), .m1_cycle(m1_cycle), .m1_strobe(m1_strobe),
    .m1_ack(m1_ack), .m1_err(m1_err),
    .wbs_address(wbs_address), .wbs_writedata(wbs_writedata), .wbs_readdata(wbs_readdata),
    .wbs_write(wbs_write), .wbs_cycle(wbs_cycle), .wbs_strobe(wbs_strobe),
    .wbs_ack(wbs_ack), .grant(grant), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_all;
    m0_address = '0; m0_writedata = '0; m0_write = 1'b0; m0_cycle = 1'b0; m0_strobe = 1'b0;
    m1_address = '0; m1_writedata = '0; m1_write = 1'b0; m1_cycle = 1'b0; m1_strobe = 1'b0;
    wbs_ack = 1'b0; wbs_readdata = '0;
  endtask

  task automatic req(input int m, input logic v);
    if (m == 0) begin m0_cycle = v; m0_strobe = v; end
    else        begin m1_cycle = v; m1_strobe = v; end
  endtask

  logic [1:0] rr_exp [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
  logic [1:0] prev_g;
  logic       a0, a1;
  int         nidx, pulses;

  initial begin
    reset = 1'b0;
    idle_all();
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_cyc", 32'(wbs_cycle), 32'h0);
    check("rst_errcnt", 32'(err_count), 32'h0);
    check("rst_m0ack", 32'(m0_ack), 32'h0);
    reset = 1'b1;
    tick();

    // single read by m0
    m0_address = 16'h0040; m0_write = 1'b0; req(0, 1'b1);
    #1 check("rd_lat0", 32'(wbs_cycle), 32'h0);
    tick();
    check("rd_grant", 32'(grant), 32'h1);
    check("rd_cyc", 32'(wbs_cycle), 32'h1);
    check("rd_addr", 32'(wbs_address), 32'h0040);
    check("rd_noack", 32'(m0_ack), 32'h0);
    tick();
    wbs_ack = 1'b1; wbs_readdata = 16'h1234;
    #1;
    check("rd_m0ack", 32'(m0_ack), 32'h1);
    check("rd_data", 32'(m0_readdata), 32'h1234);
    check("rd_m1ack", 32'(m1_ack), 32'h0);
    check("rd_m0err", 32'(m0_err), 32'h0);
    tick();
    req(0, 1'b0); wbs_ack = 1'b0;
    tick();
    check("rd_idle", 32'(grant), 32'h0);

    // simultaneous request straight after reset: m0 first
    reset = 1'b0; tick(); reset = 1'b1;
    req(0, 1'b1); req(1, 1'b1);
    tick();
    check("sim_grant0", 32'(grant), 32'h1);
    wbs_ack = 1'b1;
    #1;
    check("sim_ack0", 32'(m0_ack), 32'h1);
    check("sim_ack1", 32'(m1_ack), 32'h0);
    tick();
    req(0, 1'b0); wbs_ack = 1'b0;
    tick();
    check("sim_gap", 32'(grant), 32'h0);
    tick();
    check("sim_grant1", 32'(grant), 32'h2);
    check("sim_cyc1", 32'(wbs_cycle), 32'h1);
    req(1, 1'b0);
    tick();
    check("sim_end", 32'(grant), 32'h0);

    // round robin: each master drops cycle for one clk after its ack
    prev_g = 2'b00; a0 = 1'b0; a1 = 1'b0; nidx = 0;
    for (int i = 0; i < 30; i++) begin
      req(0, !a0); req(1, !a1);
      #1 wbs_ack = wbs_cycle;
      #1;
      a0 = m0_ack; a1 = m1_ack;
      if (grant != prev_g && nidx < 8) begin
        check($sformatf("rr_seq%0d", nidx), 32'(grant), 32'(rr_exp[nidx]));
        nidx++;
        prev_g = grant;
      end
      tick();
    end
    check("rr_count", 32'(nidx), 32'd8);
    idle_all();
    tick(); tick(); tick();

    // watchdog timeout on m1
    req(1, 1'b1);
    tick();
    check("to_grant", 32'(grant), 32'h2);
    tick(); tick(); tick();
    check("to_cyc4", 32'(wbs_cycle), 32'h1);
    check("to_err4", 32'(m1_err), 32'h0);
    tick();
    wbs_ack = 1'b1;
    #1;
    check("to_err", 32'(m1_err), 32'h1);
    check("to_cyc", 32'(wbs_cycle), 32'h0);
    check("to_stb", 32'(wbs_strobe), 32'h0);
    check("to_ack", 32'(m1_ack), 32'h0);
    check("to_m0err", 32'(m0_err), 32'h0);
    wbs_ack = 1'b0;
    tick();
    check("to_cnt", 32'(err_count), 32'h1);
    check("to_idle", 32'(grant), 32'h0);
    check("to_errclr", 32'(m1_err), 32'h0);
    tick();
    check("to_rearb", 32'(grant), 32'h2);
    req(1, 1'b0);
    tick();

    // ack on the exact timeout clk wins
    req(0, 1'b1);
    tick(); tick(); tick(); tick();
    wbs_ack = 1'b1;
    #1;
    check("bd_ack", 32'(m0_ack), 32'h1);
    check("bd_err", 32'(m0_err), 32'h0);
    tick();
    req(0, 1'b0); wbs_ack = 1'b0;
    #1;
    check("bd_noterm", 32'(m0_err), 32'h0);
    check("bd_cnt", 32'(err_count), 32'h1);
    tick();
    check("bd_cnt2", 32'(err_count), 32'h1);

    // err_count saturation
    pulses = 0;
    req(0, 1'b1);
    for (int i = 0; i < 3000 && pulses < 258; i++) begin
      tick();
      if (m0_err) pulses++;
    end
    check("sat_pulses", 32'(pulses), 32'd258);
    idle_all();
    tick(); tick();
    check("sat_cnt", 32'(err_count), 32'd255);

    // reset in the middle of a cycle
    req(1, 1'b1);
    tick();
    check("mr_cyc", 32'(wbs_cycle), 32'h1);
    reset = 1'b0; req(0, 1'b1);
    tick();
    check("mr_grant", 32'(grant), 32'h0);
    check("mr_cyc0", 32'(wbs_cycle), 32'h0);
    check("mr_cnt", 32'(err_count), 32'h0);
    reset = 1'b1;
    tick();
    check("mr_first", 32'(grant), 32'h1);
    idle_all();
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
